// File: rtl/logic_op_pkg.sv
// Shared opcode constants and FSM state type for logic_op_scheduler.
// Imported by logic_unit and logic_op_scheduler.
package logic_op_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit shared by both requesters.
// Ports: op_i opcode, a_i/b_i operands, y_o result, err_o illegal opcode.
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             err_o
);

    always_comb begin
        y_o   = '0;
        err_o = 1'b0;
        case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XOR:  y_o = a_i ^ b_i;
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler time-sharing one logic_unit between two requesters,
// with a one-entry result register, valid/ready handshakes and per-requester
// delivery counters. Ports: clk/reset, req0_*/req1_* request channels,
// res_* result channel, done_cnt0/done_cnt1 delivered-result counters.
module logic_op_scheduler
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_err,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic             id_q;
    logic             err_q;
    logic             prio_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    logic             can_accept;
    logic             grant;
    logic             accept;
    logic             res_xfer;
    logic [2:0]       op_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] y_d;
    logic             err_d;

    assign res_valid  = (state_q == FULL);
    assign res_xfer   = res_valid && res_ready;
    assign can_accept = !res_valid || res_ready;

    // prio_q names the requester that wins a tie; a lone requester always wins.
    assign grant = (req0_valid && req1_valid) ? prio_q : req1_valid;

    assign req0_ready = !reset && can_accept && req0_valid && !grant;
    assign req1_ready = !reset && can_accept && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign op_d = grant ? req1_op : req0_op;
    assign a_d  = grant ? req1_a  : req0_a;
    assign b_d  = grant ? req1_b  : req0_b;

    logic_unit #(.WIDTH(WIDTH)) u_lu (
        .op_i  (op_d),
        .a_i   (a_d),
        .b_i   (b_d),
        .y_o   (y_d),
        .err_o (err_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            prio_q  <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            // A new accept overwrites the slot even while the old result
            // leaves, so the FSM stays FULL in that case.
            if (accept) begin
                state_q <= FULL;
                data_q  <= y_d;
                id_q    <= grant;
                err_q   <= err_d;
                prio_q  <= ~grant;
            end else if (res_xfer) begin
                state_q <= EMPTY;
            end
            if (res_xfer) begin
                if (id_q) cnt1_q <= cnt1_q + CNT_ONE;
                else      cnt0_q <= cnt0_q + CNT_ONE;
            end
        end
    end

    assign res_data  = data_q;
    assign res_id    = id_q;
    assign res_err   = err_q;
    assign done_cnt0 = cnt0_q;
    assign done_cnt1 = cnt1_q;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed self-checking bench for logic_op_scheduler (CNT_W=2 so the
// counter wrap is reachable with a handful of results).
module tb_logic_op_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_op = '0, req1_op = '0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       res_valid, res_ready = 1'b1;
    logic [7:0] res_data;
    logic       res_id, res_err;
    logic [1:0] done_cnt0, done_cnt1;

    int checks = 0;
    int failures = 0;

    logic       m_valid = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_id = 1'b0, m_err = 1'b0;
    logic [1:0] m_cnt0 = '0, m_cnt1 = '0;

    logic [1:0] wrap_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    always #5 clk = ~clk;

    logic_op_scheduler #(.WIDTH(8), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .res_err(res_err),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".valid"}, res_valid, m_valid);
        chk({tag, ".data"}, res_data, m_data);
        chk({tag, ".id"}, res_id, m_id);
        chk({tag, ".err"}, res_err, m_err);
        chk({tag, ".cnt0"}, done_cnt0, m_cnt0);
        chk({tag, ".cnt1"}, done_cnt1, m_cnt1);
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, ".rdy0"}, req0_ready, r0);
        chk({tag, ".rdy1"}, req1_ready, r1);
    endtask

    // One clock edge; model the expected result register and counters.
    task automatic tick(input string tag, input logic acc,
                        input logic [7:0] d, input logic id, input logic err);
        @(posedge clk);
        #1;
        if (m_valid && res_ready) begin
            if (m_id) m_cnt1++;
            else      m_cnt0++;
        end
        if (acc) begin
            m_valid = 1'b1;
            m_data  = d;
            m_id    = id;
            m_err   = err;
        end else if (res_ready) begin
            m_valid = 1'b0;
        end
        chk_outs(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_err = 1'b0;
        m_cnt0 = '0; m_cnt1 = '0;
        chk_outs(tag);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        chk_rdy({tag, ".inrst"}, 1'b0, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        do_reset("rst");

        // Single request, sink ready: F0 & 3C = 30
        req0_valid = 1'b1; req0_op = 3'd0;
        req0_a = 8'hF0; req0_b = 8'h3C;
        chk_rdy("single", 1'b1, 1'b0);
        tick("single.acc", 1'b1, 8'h30, 1'b0, 1'b0);
        req0_valid = 1'b0;
        tick("single.dlv", 1'b0, 8'h30, 1'b0, 1'b0);
        chk("single.cnt0", done_cnt0, 2'd1);

        // Round robin from reset: grants 0,1,0,1
        do_reset("rst2");
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 8'hAA; req0_b = 8'h0F;
        req1_valid = 1'b1; req1_op = 3'd3; req1_a = 8'h00; req1_b = 8'h00;
        for (int i = 0; i < 4; i++) begin
            chk_rdy("rr", (i % 2) == 0, (i % 2) == 1);
            if ((i % 2) == 0) tick("rr.r0", 1'b1, 8'hA5, 1'b0, 1'b0);
            else              tick("rr.r1", 1'b1, 8'hFF, 1'b1, 1'b0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick("rr.drain", 1'b0, 8'hFF, 1'b1, 1'b0);
        chk("rr.cnt0", done_cnt0, 2'd2);
        chk("rr.cnt1", done_cnt1, 2'd2);

        // Backpressure: 12 | 40 = 52 held for 3 cycles
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'h12; req0_b = 8'h40;
        chk_rdy("bp.acc", 1'b1, 1'b0);
        tick("bp.acc", 1'b1, 8'h52, 1'b0, 1'b0);
        res_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'hFF; req1_b = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            chk_rdy("bp.stall", 1'b0, 1'b0);
            tick("bp.stall", 1'b0, 8'h52, 1'b0, 1'b0);
        end
        res_ready = 1'b1;
        chk_rdy("bp.rel", 1'b0, 1'b1);
        tick("bp.rel", 1'b1, 8'h0F, 1'b1, 1'b0);
        chk("bp.once", done_cnt0, 2'd3);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick("bp.drain", 1'b0, 8'h0F, 1'b1, 1'b0);

        // Illegal opcode on req1
        req1_valid = 1'b1; req1_op = 3'd6; req1_a = 8'hFF; req1_b = 8'hFF;
        chk_rdy("ill", 1'b0, 1'b1);
        tick("ill.acc", 1'b1, 8'h00, 1'b1, 1'b1);
        req1_valid = 1'b0;
        tick("ill.dlv", 1'b0, 8'h00, 1'b1, 1'b1);
        chk("ill.cnt1", done_cnt1, 2'd0);

        // Reset while FULL: FF nand 0F = F0
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 8'hFF; req0_b = 8'h0F;
        res_ready = 1'b0;
        tick("rf.acc", 1'b1, 8'hF0, 1'b0, 1'b0);
        do_reset("rf.rst");
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'hFF; req0_b = 8'h01;
        req1_valid = 1'b1;
        chk_rdy("rf.prio", 1'b1, 1'b0);
        req1_valid = 1'b0;

        // Counter wrap on req0: 1,2,3,0,1
        for (int i = 0; i < 6; i++) begin
            if (i == 5) req0_valid = 1'b0;
            else        chk_rdy("wrap", 1'b1, 1'b0);
            tick("wrap", i < 5, 8'h01, 1'b0, 1'b0);
            if (i >= 1) chk("wrap.seq", done_cnt0, wrap_seq[i-1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/logic_op_scheduler.md
LOGIC_OP_SCHEDULER -- requirements
Module: logic_op_scheduler

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width.
REQ-002 Parameter: CNT_W, default 16, width of per-requester completion counters.
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-high. Ports are listed below as name, direction, width, meaning.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0_valid, req1_valid  input  1 each  requester i has an operation pending.
REQ-007 req0_ready, req1_ready  output  1 each  operation of requester i is accepted this cycle.
REQ-008 req0_op, req1_op  input  3 each  opcode: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5-7 illegal.
REQ-009 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-010 res_valid  output  1  result register holds a result.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 res_data  output  WIDTH  bitwise result.
REQ-013 res_id  output  1  index of the requester that owns the result.
REQ-014 res_err  output  1  the opcode was illegal.
REQ-015 done_cnt0, done_cnt1  output  CNT_W each  results delivered per requester.

Function
REQ-016 A single shared bitwise logic unit SHALL be time-shared between the two requesters.
REQ-017 Transfer rules: a requester transfer occurs when reqi_valid and reqi_ready are both high; a result transfer occurs when res_valid and res_ready are both high.
REQ-018 can_accept = !res_valid || res_ready (full throughput, no bubble).
REQ-019 reqi_ready SHALL be combinational: high only when can_accept is high and requester i holds the grant; at most one ready is high per cycle.
REQ-020 Grant SHALL be round-robin.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not served by the last accepted transfer is granted.
  - After reset, req0 has priority.
REQ-021 The priority pointer SHALL update only on an accepted requester transfer; an offered but unaccepted grant does not move it.
REQ-022 Result latency SHALL be 1 cycle: on accept, res_data/res_id/res_err load on the next edge and res_valid goes high.
REQ-023 Opcode results are per bit: res_data = a&b, a|b, ~(a&b), ~(a|b) or a^b.
REQ-024 Illegal opcode: res_data = 0 and res_err = 1; the result is still delivered and counted.
REQ-025 FSM states:
  - EMPTY (res_valid = 0): go to FULL on accept.
  - FULL (res_valid = 1): go to EMPTY on result transfer with no accept; stay FULL on result transfer with a simultaneous accept (new result replaces the old one); stay FULL and hold all outputs stable while res_ready = 0.
REQ-026 done_cnt[res_id] SHALL increment on each result transfer and wrap from 2^CNT_W-1 to 0.
REQ-027 Requesters are required to hold valid/op/operands stable until ready; the block SHALL NOT latch operands before accept.
REQ-028 Simultaneous accept and result transfer SHALL lose no result and duplicate no result.

Reset
REQ-029 When reset is high at a clock edge, the following SHALL clear: res_valid = 0, res_data = 0, res_id = 0, res_err = 0, done_cnt0/1 = 0, FSM = EMPTY, priority pointer = req0.
REQ-030 Reset mid-operation SHALL discard any held result; req ready outputs SHALL be low during the reset cycle.
REQ-031 The first accept after reset SHALL occur no earlier than the first edge with reset low.

Structure
REQ-032 A shared package logic_op_pkg SHALL hold:
  - opcode constants OP_AND=0, OP_OR=1, OP_NAND=2, OP_NOR=3, OP_XOR=4;
  - the FSM state type {EMPTY, FULL}.
REQ-033 One sub-module, logic_unit (WIDTH-parameterised, purely combinational: op, a, b -> y, err), SHALL implement the shared datapath and be instantiated once.

Verification
REQ-034 Single request, sink always ready: reset, then req0 op=0 a=8'hF0 b=8'h3C -> next cycle res_valid=1, res_data=8'h30, res_id=0, done_cnt0=1.
REQ-035 Both requesters valid continuously, res_ready=1, req0 XOR 8'hAA^8'h0F, req1 NOR 8'h00,8'h00 -> grants alternate 0,1,0,1; results 8'hA5 / 8'hFF every cycle.
REQ-036 Backpressure: res_ready=0 for 3 cycles after a result -> res_valid/res_data stable, both ready outputs low, no counter change; release -> delivered exactly once.
REQ-037 Illegal opcode 6 on req1 -> res_data=0, res_err=1, res_id=1, done_cnt1 increments.
REQ-038 Reset asserted while FULL -> next cycle res_valid=0, counters 0; with both requesters valid, req0 granted first.
REQ-039 Counter wrap with CNT_W=2: 5 results on req0 -> done_cnt0 sequence 1,2,3,0,1.
